// File: rtl/add6_arb.sv
// Two-port round-robin arbiter feeding a shared six-operand 4-bit adder.
// Two pipeline stages: operand register (stage 1) and result register.
module add6_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [23:0]      req0_ops,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [23:0]      req1_ops,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [6:0]       res_sum,
  output logic             res_tag,
  output logic             busy,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt
);

  logic             s1_valid_q;
  logic [23:0]      s1_ops_q;
  logic             s1_tag_q;
  logic             res_valid_q;
  logic [6:0]       res_sum_q;
  logic             res_tag_q;
  logic             ptr_q;
  logic [CNT_W-1:0] done0_q;
  logic [CNT_W-1:0] done1_q;

  logic       res_adv;
  logic       can_accept;
  logic       win0;
  logic       win1;
  logic       acc0;
  logic       acc1;
  logic       drain;
  logic [6:0] sum_d;

  assign res_adv    = !res_valid_q || res_ready;
  assign can_accept = !s1_valid_q || res_adv;

  // Contention goes to the port the pointer favours; a lone requester always wins.
  assign win0 = req0_valid && (!req1_valid || !ptr_q);
  assign win1 = req1_valid && (!req0_valid || ptr_q);

  assign req0_ready = !rst && can_accept && win0;
  assign req1_ready = !rst && can_accept && win1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign drain      = res_valid_q && res_ready;

  always_comb begin
    sum_d = 7'd0;
    for (int k = 0; k < 6; k++) begin
      sum_d = sum_d + {3'b000, s1_ops_q[4*k +: 4]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_ops_q    <= 24'd0;
      s1_tag_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= 7'd0;
      res_tag_q   <= 1'b0;
      ptr_q       <= 1'b0;
      done0_q     <= '0;
      done1_q     <= '0;
    end else begin
      if (can_accept) begin
        s1_valid_q <= acc0 || acc1;
        if (acc0) begin
          s1_ops_q <= req0_ops;
          s1_tag_q <= 1'b0;
        end else if (acc1) begin
          s1_ops_q <= req1_ops;
          s1_tag_q <= 1'b1;
        end
      end
      if (res_adv) begin
        res_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_sum_q <= sum_d;
          res_tag_q <= s1_tag_q;
        end
      end
      if (acc0) begin
        ptr_q <= 1'b1;
      end else if (acc1) begin
        ptr_q <= 1'b0;
      end
      if (drain && !res_tag_q) begin
        done0_q <= done0_q + 1'b1;
      end
      if (drain && res_tag_q) begin
        done1_q <= done1_q + 1'b1;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_tag   = res_tag_q;
  assign busy      = s1_valid_q || res_valid_q;
  assign done0_cnt = done0_q;
  assign done1_cnt = done1_q;

endmodule

// File: tb/tb_add6_arb.sv
// Directed bench for add6_arb; a second instance with CNT_W=2 covers counter wrap.
module tb_add6_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic [23:0] req0_ops;
  logic        req0_ready;
  logic        req1_valid;
  logic [23:0] req1_ops;
  logic        req1_ready;
  logic        res_valid;
  logic        res_ready;
  logic [6:0]  res_sum;
  logic        res_tag;
  logic        busy;
  logic [7:0]  done0_cnt;
  logic [7:0]  done1_cnt;

  logic        s_req0_ready;
  logic        s_req1_ready;
  logic        s_res_valid;
  logic [6:0]  s_res_sum;
  logic        s_res_tag;
  logic        s_busy;
  logic [1:0]  s_done0_cnt;
  logic [1:0]  s_done1_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  add6_arb #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ops(req0_ops), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_ops(req1_ops), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_tag(res_tag), .busy(busy), .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
  );

  add6_arb #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ops(req0_ops), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_ops(req1_ops), .req1_ready(s_req1_ready),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_sum(s_res_sum),
    .res_tag(s_res_tag), .busy(s_busy), .done0_cnt(s_done0_cnt), .done1_cnt(s_done1_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b1;
    req0_ops   = 24'hFFFFFF;
    req1_valid = 1'b1;
    req1_ops   = 24'd0;
    res_ready  = 1'b0;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    tick();
    tick();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done0", done0_cnt, 0);
    chk("rst_done1", done1_cnt, 0);

    // single op, all 0xF
    rst        = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    #1;
    chk("single_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("single_busy_s1", busy, 1);
    chk("single_res_valid_early", res_valid, 0);
    tick();
    chk("single_res_valid", res_valid, 1);
    chk("single_sum", res_sum, 90);
    chk("single_tag", res_tag, 0);
    chk("single_done0_pre", done0_cnt, 0);
    tick();
    chk("single_done0", done0_cnt, 1);
    chk("single_drained", res_valid, 0);
    chk("single_idle", busy, 0);

    // ops 1..6, then all zeros from port 1 overlapping the drain
    req0_valid = 1'b1;
    req0_ops   = 24'h654321;
    #1;
    chk("w21_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("w21_sum", res_sum, 21);
    chk("w21_valid", res_valid, 1);
    req1_valid = 1'b1;
    req1_ops   = 24'd0;
    #1;
    chk("zero_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("zero_done0", done0_cnt, 2);
    tick();
    chk("zero_valid", res_valid, 1);
    chk("zero_sum", res_sum, 0);
    chk("zero_tag", res_tag, 1);
    tick();
    chk("zero_done1", done1_cnt, 1);

    // round robin: both ports valid for 6 accepts
    req0_valid = 1'b1;
    req0_ops   = 24'h111111;
    req1_valid = 1'b1;
    req1_ops   = 24'h222222;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
      if (i >= 2) begin
        chk("rr_tag", res_tag, (i - 2) % 2);
        chk("rr_sum", res_sum, ((i - 2) % 2 == 0) ? 6 : 12);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_tag4", res_tag, 0);
    chk("rr_sum4", res_sum, 6);
    tick();
    chk("rr_tag5", res_tag, 1);
    chk("rr_sum5", res_sum, 12);
    tick();
    chk("rr_done0", done0_cnt, 5);
    chk("rr_done1", done1_cnt, 4);
    chk("rr_idle", busy, 0);

    // backpressure: three port-0 requests with res_ready low
    res_ready  = 1'b0;
    req0_valid = 1'b1;
    req0_ops   = 24'h000001;
    #1;
    chk("bp_ready_a", req0_ready, 1);
    tick();
    req0_ops = 24'h000002;
    #1;
    chk("bp_ready_b", req0_ready, 1);
    tick();
    req0_ops = 24'h000003;
    #1;
    chk("bp_ready_c", req0_ready, 0);
    chk("bp_ready_c1", req1_ready, 0);
    tick();
    chk("bp_hold_ready", req0_ready, 0);
    chk("bp_hold_valid", res_valid, 1);
    chk("bp_hold_sum", res_sum, 1);
    chk("bp_hold_tag", res_tag, 0);
    tick();
    chk("bp_hold_sum2", res_sum, 1);
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("bp_drain_b", res_sum, 2);
    tick();
    chk("bp_drain_c", res_sum, 3);
    chk("bp_drain_c_valid", res_valid, 1);
    tick();
    chk("bp_drained", res_valid, 0);
    chk("bp_done0", done0_cnt, 8);

    // reset with both stages full
    res_ready  = 1'b0;
    req1_valid = 1'b1;
    req1_ops   = 24'h000005;
    tick();
    req1_ops = 24'h000006;
    tick();
    req1_valid = 1'b0;
    chk("mid_full", busy, 1);
    chk("mid_res_valid", res_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_res_valid_clr", res_valid, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_done0", done0_cnt, 0);
    chk("mid_done1", done1_cnt, 0);
    chk("mid_sum", res_sum, 0);
    res_ready  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_ptr0", req0_ready, 1);
    chk("mid_ptr1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    chk("mid_no_partial", res_valid, 0);

    // counter wrap on the CNT_W=2 instance
    req1_valid = 1'b1;
    req1_ops   = 24'h000007;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 4) req1_valid = 1'b0;
      if (i >= 2) chk("wrap_done1", s_done1_cnt, (i - 1) % 4);
    end
    chk("wrap_big_done1", done1_cnt, 5);
    chk("wrap_small_done0", s_done0_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/add6_arb.md
Name: add6_arb

Overview:
- Two-requester round-robin arbiter and pipeline controller that shares one six-operand 4-bit adder between two clients.
- Each client offers six 4-bit operands with a valid/ready handshake.
- The block grants one client per cycle, registers the operands, adds them, and holds a tagged 7-bit result in an output register with valid/ready backpressure.
- Sits between operand producers and the downstream consumer of sums.

Parameters:
- CNT_W, 8, width of the per-port completed-result counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 has operands.
- req0_ops  input  24  port 0 operands; op k = bits [4k+3:4k], k=0..5.
- req0_ready  output  1  port 0 operands accepted this cycle when valid&ready.
- req1_valid  input  1  port 1 has operands.
- req1_ops  input  24  port 1 operands, same packing.
- req1_ready  output  1  port 1 accept.
- res_valid  output  1  result register holds a sum.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  7  exact unsigned sum of the six operands (0..90).
- res_tag  output  1  originating port of res_sum.
- busy  output  1  high when stage 1 or the result register is occupied.
- done0_cnt  output  CNT_W  results delivered for port 0; wraps.
- done1_cnt  output  CNT_W  results delivered for port 1; wraps.

Behaviour:
- Reset (rst=1 at a clk edge):
  - s1_valid=0, res_valid=0, res_sum=0, res_tag=0.
  - Priority pointer=0 (port 0 favoured), done0_cnt=0, done1_cnt=0.
  - While rst is high, req0_ready=req1_ready=0.
- Reset mid-operation discards all in-flight work. Nothing partial is emitted afterwards.
- Pipeline:
  - Stage 1 holds {ops, tag, s1_valid}.
  - Result register holds {res_sum, res_tag, res_valid}.
- Advance conditions:
  - res_adv = !res_valid | res_ready.
  - s1_adv = s1_valid & res_adv.
  - can_accept = !s1_valid | res_adv.
- Arbitration (combinational):
  - If exactly one reqN_valid is high, that port wins.
  - If both are high, the port equal to the pointer wins.
  - reqN_ready = can_accept & win_N.
  - The loser's ready is 0.
  - reqN_ready may depend on reqN_valid in the same cycle.
- Pointer update: on every accepted request from port i, pointer <= 1-i. With no accept, the pointer holds.
- Requester rule: once valid is asserted, ops must stay stable until ready. Arbiter behaviour is undefined if this is violated.
- Accept edge T: stage 1 loads ops and tag; s1_valid=1.
- Adder: res_sum is the 7-bit exact sum of the six stage-1 operands. There is no truncation and no wrap.
- Edge T+1 with res_adv: the result register loads; res_valid=1.
- Latency:
  - Minimum 2 cycles from accept to res_valid visible.
  - Throughput is one result per cycle when res_ready is held high.
- Edge where s1_valid=0 but res_ready&res_valid: res_valid <= 0.
- Simultaneous events:
  - Result drain, stage-1 advance and a new accept can all happen on the same edge; no bubble is inserted.
  - A full pipe (s1_valid=1, res_valid=1) with res_ready=0 forces both readies to 0. Stage 1 and the result register hold their contents unchanged.
- Counters: doneN_cnt increments on res_valid&res_ready&(res_tag==N). It wraps from 2^CNT_W-1 to 0.
- busy = s1_valid | res_valid.

Test Plan:
- Reset then single op:
  - Stimulus: port 0 ops all 4'hF; res_ready=1.
  - Response: req0_ready=1 at T; res_valid=1 after edge T+1; res_sum=90, res_tag=0; done0_cnt=1 after the drain edge.
- Exact width:
  - Stimulus: ops {1,2,3,4,5,6}.
  - Response: res_sum=21.
  - Stimulus: all zeros.
  - Response: res_sum=0 with res_valid=1.
- Round-robin contention:
  - Stimulus: both ports valid continuously for 6 cycles; res_ready=1.
  - Response: accepts alternate 0,1,0,1,0,1; res_tag follows the same order; done0_cnt=done1_cnt=3.
- Backpressure:
  - Stimulus: res_ready=0 while issuing 3 port-0 requests.
  - Response: 2 accepted, third sees req0_ready=0; res_sum/res_tag stable.
  - Stimulus: raise res_ready.
  - Response: results drain back-to-back in order.
- Reset mid-operation:
  - Stimulus: rst=1 for one cycle with s1_valid=1 and res_valid=1.
  - Response: next cycle res_valid=0, busy=0, counters=0, pointer favours port 0.
- Counter wrap:
  - Stimulus: CNT_W=2; deliver 5 port-1 results.
  - Response: done1_cnt sequence 1,2,3,0,1.
